// File: rtl/varray_pkg.sv
// Shared sizing defaults and types for the varray stream controller.
// The drain FSM states and the skid entry layout live here so the bench can reuse them.
package varray_pkg;

    localparam int unsigned DEF_VIRTUAL_ELEMENT_WIDTH = 32'd4;
    localparam int unsigned DEF_VIRTUAL_ADDR_BITS     = 32'd16;
    localparam int unsigned DEF_LEN_BITS              = 32'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [DEF_VIRTUAL_ELEMENT_WIDTH-1:0] data;
        logic [DEF_VIRTUAL_ADDR_BITS-1:0]     addr;
        logic                                 last;
    } skid_entry_t;

endpackage

// File: rtl/varray_skid.sv
// Two-entry FIFO that absorbs varray read data while the downstream consumer stalls.
// Pushes into a full buffer and pops from an empty one are ignored.
module varray_skid
    import varray_pkg::*;
#(
    parameter int unsigned W = 32'd21
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_occ,
    output logic         o_empty
);

    logic [W-1:0] r_mem [0:1];
    logic         r_wr_idx;
    logic         r_rd_idx;
    logic [1:0]   r_occ;
    logic         w_push;
    logic         w_pop;

    // Qualify push/pop against the current fill level.
    always_comb begin
        w_push = i_push && (r_occ != 2'd2);
        w_pop  = i_pop && (r_occ != 2'd0);
    end

    // Entry storage, read/write pointers and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= {W{1'b0}};
            r_mem[1] <= {W{1'b0}};
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_idx] <= i_push_data;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_idx];
    assign o_occ   = r_occ;
    assign o_empty = (r_occ == 2'd0);

endmodule

// File: rtl/varray_stream_ctrl.sv
// Shares one varray between a run-length writer and a sequential drain engine that
// streams elements 0..len-1 on a valid/ready port, hiding the 1-cycle read latency.
module varray_stream_ctrl
    import varray_pkg::*;
#(
    parameter int unsigned VIRTUAL_ELEMENT_WIDTH = DEF_VIRTUAL_ELEMENT_WIDTH,
    parameter int unsigned VIRTUAL_ADDR_BITS     = DEF_VIRTUAL_ADDR_BITS,
    parameter int unsigned LEN_BITS              = DEF_LEN_BITS
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [VIRTUAL_ADDR_BITS-1:0]     wr_addr,
    input  logic [LEN_BITS-1:0]              wr_len,
    input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] wr_data,
    input  logic                             drain_start,
    output logic                             drain_busy,
    output logic                             drain_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0] out_data,
    output logic [VIRTUAL_ADDR_BITS-1:0]     out_addr,
    output logic                             out_last,
    output logic                             va_we,
    output logic [VIRTUAL_ADDR_BITS-1:0]     va_write_addr,
    output logic [LEN_BITS-1:0]              va_write_addr_len,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0] va_dat_w,
    output logic                             va_re,
    output logic [VIRTUAL_ADDR_BITS-1:0]     va_read_addr,
    input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] va_dat_r,
    input  logic [VIRTUAL_ADDR_BITS-1:0]     va_varray_len
);

    typedef struct packed {
        logic [VIRTUAL_ELEMENT_WIDTH-1:0] data;
        logic [VIRTUAL_ADDR_BITS-1:0]     addr;
        logic                             last;
    } entry_t;

    localparam logic [VIRTUAL_ADDR_BITS-1:0] ADDR_ZERO = {VIRTUAL_ADDR_BITS{1'b0}};
    localparam logic [VIRTUAL_ADDR_BITS-1:0] ADDR_ONE  = {{(VIRTUAL_ADDR_BITS-1){1'b0}}, 1'b1};

    drain_state_e                 r_state;
    drain_state_e                 w_state_nxt;
    logic [VIRTUAL_ADDR_BITS-1:0] r_len_q;
    logic [VIRTUAL_ADDR_BITS-1:0] r_rd_ptr;
    logic [VIRTUAL_ADDR_BITS-1:0] r_if_addr;
    logic                         r_inflight;
    logic                         r_if_last;
    logic                         r_done;

    logic                         w_start;
    logic                         w_va_re;
    logic [1:0]                   w_pending;
    logic [1:0]                   w_skid_occ;
    logic                         w_skid_empty;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_out_valid;
    logic                         w_last_hs;
    entry_t                       w_if_entry;
    entry_t                       w_head;
    entry_t                       w_out_entry;

    // Read issue, output selection and skid buffer push/pop control.
    always_comb begin
        w_start     = (r_state == IDLE) && drain_start;
        w_pending   = w_skid_occ + {1'b0, r_inflight};
        w_va_re     = (r_state == DRAIN) && (r_rd_ptr < r_len_q) && (w_pending < 2'd2);
        w_if_entry  = '{data: va_dat_r, addr: r_if_addr, last: r_if_last};
        w_out_valid = !w_skid_empty || r_inflight;
        // Returning read data bypasses the buffer when nothing older is queued.
        if (!w_skid_empty) begin
            w_out_entry = w_head;
        end else if (r_inflight) begin
            w_out_entry = w_if_entry;
        end else begin
            w_out_entry = '{data: {VIRTUAL_ELEMENT_WIDTH{1'b0}}, addr: ADDR_ZERO, last: 1'b0};
        end
        w_push    = r_inflight && !(w_skid_empty && out_ready);
        w_pop     = !w_skid_empty && out_ready;
        w_last_hs = (r_state == DRAIN) && w_out_valid && out_ready && w_out_entry.last;
    end

    // Drain FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start && (va_varray_len != ADDR_ZERO)) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (w_last_hs) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, length snapshot, read pointer, in-flight tag and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_len_q    <= ADDR_ZERO;
            r_rd_ptr   <= ADDR_ZERO;
            r_if_addr  <= ADDR_ZERO;
            r_inflight <= 1'b0;
            r_if_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= (w_start && (va_varray_len == ADDR_ZERO)) || w_last_hs;
            r_inflight <= w_va_re;
            if (w_start) begin
                r_len_q  <= va_varray_len;
                r_rd_ptr <= ADDR_ZERO;
            end else if (w_va_re) begin
                r_rd_ptr <= r_rd_ptr + ADDR_ONE;
            end
            if (w_va_re) begin
                r_if_addr <= r_rd_ptr;
                r_if_last <= (r_rd_ptr == (r_len_q - ADDR_ONE));
            end
        end
    end

    varray_skid #(
        .W ($bits(entry_t))
    ) u_skid (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_push      (w_push),
        .i_push_data (w_if_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_skid_occ),
        .o_empty     (w_skid_empty)
    );

    // The write path is a gated pass-through so every output reads 0 while in reset.
    assign wr_ready          = reset && (r_state == IDLE) && !drain_start;
    assign va_we             = wr_valid && wr_ready && (wr_len != {LEN_BITS{1'b0}});
    assign va_write_addr     = reset ? wr_addr : ADDR_ZERO;
    assign va_write_addr_len = reset ? wr_len : {LEN_BITS{1'b0}};
    assign va_dat_w          = reset ? wr_data : {VIRTUAL_ELEMENT_WIDTH{1'b0}};

    assign va_re        = w_va_re;
    assign va_read_addr = r_rd_ptr;
    assign out_valid    = w_out_valid;
    assign out_data     = w_out_entry.data;
    assign out_addr     = w_out_entry.addr;
    assign out_last     = w_out_entry.last;
    assign drain_busy   = (r_state == DRAIN);
    assign drain_done   = r_done;

endmodule

// File: tb/tb_varray_stream_ctrl.sv
// Scoreboard bench for varray_stream_ctrl with a behavioural varray model.
module tb_varray_stream_ctrl;
    import varray_pkg::*;

    localparam int EW = DEF_VIRTUAL_ELEMENT_WIDTH;
    localparam int AW = DEF_VIRTUAL_ADDR_BITS;
    localparam int LW = DEF_LEN_BITS;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_len;
    logic [EW-1:0] wr_data;
    logic          drain_start;
    logic          drain_busy;
    logic          drain_done;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          va_we;
    logic [AW-1:0] va_write_addr;
    logic [LW-1:0] va_write_addr_len;
    logic [EW-1:0] va_dat_w;
    logic          va_re;
    logic [AW-1:0] va_read_addr;
    logic [EW-1:0] va_dat_r = '0;
    logic [AW-1:0] va_varray_len = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int re_count = 0;
    int first_re = -1;
    int first_v = -1;
    skid_entry_t exp_q[$];
    logic clr_mem = 1'b1;
    logic [EW-1:0] mem [0:255];

    varray_stream_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_addr           (wr_addr),
        .wr_len            (wr_len),
        .wr_data           (wr_data),
        .drain_start       (drain_start),
        .drain_busy        (drain_busy),
        .drain_done        (drain_done),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_addr          (out_addr),
        .out_last          (out_last),
        .va_we             (va_we),
        .va_write_addr     (va_write_addr),
        .va_write_addr_len (va_write_addr_len),
        .va_dat_w          (va_dat_w),
        .va_re             (va_re),
        .va_read_addr      (va_read_addr),
        .va_dat_r          (va_dat_r),
        .va_varray_len     (va_varray_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    // varray model: run-length writes, length = highest written end, 1-cycle read latency
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            va_varray_len <= '0;
        end else if (va_we) begin
            for (int i = 0; i < int'(va_write_addr_len); i++)
                mem[(int'(va_write_addr) + i) % 256] <= va_dat_w;
            if (int'(va_write_addr) + int'(va_write_addr_len) > int'(va_varray_len))
                va_varray_len <= AW'(int'(va_write_addr) + int'(va_write_addr_len));
        end
        if (va_re) va_dat_r <= mem[va_read_addr[7:0]];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_data(input int a);
        if (a < 4) return 12;
        else if (a < 7) return 6;
        else if (a == 20 || a == 21) return 9;
        else return 0;
    endfunction

    task automatic push_beats(input int n_total, input int n_push);
        skid_entry_t e;
        for (int a = 0; a < n_push; a++) begin
            e.addr = AW'(a);
            e.data = EW'(exp_data(a));
            e.last = (a == n_total - 1);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin : monitor
        skid_entry_t e;
        skid_entry_t held;
        bit hold_v;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_v = 1'b0;
            end else begin
                if (va_re) begin
                    re_count++;
                    if (first_re < 0) first_re = cyc;
                end
                if (out_valid && first_v < 0) first_v = cyc;
                if (hold_v) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, held.data);
                    chk("stall_addr", out_addr, held.addr);
                    chk("stall_last", out_last, held.last);
                end
                if (out_valid && out_ready) begin
                    chk("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat_data", out_data, e.data);
                        chk("beat_addr", out_addr, e.addr);
                        chk("beat_last", out_last, e.last);
                    end
                end
                held   = '{data: out_data, addr: out_addr, last: out_last};
                hold_v = out_valid && !out_ready;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int l, input int d, input int exp_we);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_len   = LW'(l);
        wr_data  = EW'(d);
        @(negedge clk);
        chk("wr_ready", wr_ready, 1);
        chk("va_we", va_we, exp_we);
        chk("va_write_addr", va_write_addr, a);
        chk("va_write_len", va_write_addr_len, l);
        chk("va_dat_w", va_dat_w, d);
        tick;
        wr_valid = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready toggles; 2: ready low for 10 cycles
    task automatic do_drain(input int mode, input bit wr_during,
                            output int done_ofs, output int re_ofs, output int v_ofs);
        int c0;
        bit done_seen;
        bit wr_leak;
        drain_start = 1'b1;
        out_ready   = (mode == 2) ? 1'b0 : 1'b1;
        first_re = -1;
        first_v  = -1;
        re_count = 0;
        @(negedge clk);
        c0 = cyc;
        if (wr_during) begin
            chk("wr_ready_at_start", wr_ready, 0);
            chk("va_we_at_start", va_we, 0);
        end
        tick;
        drain_start = 1'b0;
        done_seen = 1'b0;
        wr_leak   = 1'b0;
        done_ofs  = -1;
        for (int k = 1; k < 200 && !done_seen; k++) begin
            if (mode == 1) out_ready = (k % 2 == 0);
            else if (mode == 2) out_ready = (k > 10);
            else out_ready = 1'b1;
            @(negedge clk);
            if (drain_done) begin
                done_seen = 1'b1;
                done_ofs  = cyc - c0;
                chk("busy_at_done", drain_busy, 0);
                chk("wr_ready_at_done", wr_ready, 1);
                if (wr_during) chk("va_we_at_done", va_we, 1);
            end else begin
                if (wr_ready || va_we) wr_leak = 1'b1;
                if (k == 1) chk("busy_first", drain_busy, 1);
                if (mode == 2 && k == 10) begin
                    chk("stall_re_count", re_count, 2);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_addr", out_addr, 0);
                    chk("stall_out_data", out_data, 12);
                end
            end
            tick;
        end
        chk("done_seen", done_seen, 1);
        chk("write_blocked", wr_leak, 0);
        wr_valid = 1'b0;
        re_ofs = (first_re < 0) ? -1 : first_re - c0;
        v_ofs  = (first_v < 0) ? -1 : first_v - c0;
        @(negedge clk);
        chk("done_one_cycle", drain_done, 0);
        chk("beats_left", exp_q.size(), 0);
        tick;
    endtask

    initial begin : stim
        int ofs, re_o, v_o;
        bit rst_done_seen;
        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_len      = '0;
        wr_data     = '0;
        drain_start = 1'b0;
        out_ready   = 1'b0;
        #2 reset = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = AW'(5);
        wr_len   = LW'(3);
        wr_data  = EW'(7);
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_va_we", va_we, 0);
        chk("rst_va_write_addr", va_write_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", drain_busy, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_va_re", va_re, 0);
        chk("rst_out_data", out_data, 0);
        wr_valid = 1'b0;
        tick;
        clr_mem = 1'b0;
        reset   = 1'b1;
        tick;

        do_write(30, 0, 5, 0);
        do_write(0, 4, 12, 1);
        do_write(4, 3, 6, 1);

        push_beats(7, 7);
        do_drain(0, 1'b0, ofs, re_o, v_o);
        chk("done_ofs_full_rate", ofs, 9);
        chk("first_re_ofs", re_o, 1);
        chk("first_valid_ofs", v_o, 2);

        push_beats(7, 7);
        do_drain(1, 1'b0, ofs, re_o, v_o);

        push_beats(7, 7);
        do_drain(2, 1'b0, ofs, re_o, v_o);

        push_beats(7, 3);
        drain_start = 1'b1;
        out_ready   = 1'b1;
        tick;
        drain_start = 1'b0;
        repeat (4) tick;
        reset = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", drain_busy, 0);
        chk("abort_va_re", va_re, 0);
        chk("abort_read_addr", va_read_addr, 0);
        chk("abort_out_addr", out_addr, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_wr_ready", wr_ready, 0);
        rst_done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (drain_done) rst_done_seen = 1'b1;
        end
        tick;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (drain_done) rst_done_seen = 1'b1;
        end
        chk("abort_no_done", rst_done_seen, 0);
        chk("abort_beats_left", exp_q.size(), 0);
        tick;
        push_beats(7, 7);
        do_drain(0, 1'b0, ofs, re_o, v_o);
        chk("done_ofs_after_abort", ofs, 9);

        clr_mem = 1'b1;
        tick;
        clr_mem = 1'b0;
        do_drain(0, 1'b0, ofs, re_o, v_o);
        chk("done_ofs_empty", ofs, 1);
        chk("re_empty", re_o, -1);
        chk("valid_empty", v_o, -1);

        do_write(0, 4, 12, 1);
        do_write(4, 3, 6, 1);
        push_beats(7, 7);
        wr_valid = 1'b1;
        wr_addr  = AW'(20);
        wr_len   = LW'(2);
        wr_data  = EW'(9);
        do_drain(0, 1'b1, ofs, re_o, v_o);
        chk("done_ofs_with_write", ofs, 9);

        push_beats(22, 22);
        do_drain(0, 1'b0, ofs, re_o, v_o);
        chk("done_ofs_len22", ofs, 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/varray_stream_ctrl.md
Name: varray_stream_ctrl

Overview:
- Controller that fronts one varray instance. It shares the varray between an upstream run-length writer and a sequential drain engine.
- The drain engine streams every element from address 0 to varray_len-1 onto a valid/ready output.
- It hides the varray's 1-cycle read latency with a 2-entry skid buffer so downstream backpressure never loses or duplicates data.

Parameters:
- VIRTUAL_ELEMENT_WIDTH, 4, bits per varray element
- VIRTUAL_ADDR_BITS, 16, varray address and length width
- LEN_BITS, 4, width of run-length field

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted this cycle when high with wr_valid
- wr_addr  in  VIRTUAL_ADDR_BITS  first address of run
- wr_len  in  LEN_BITS  run length
- wr_data  in  VIRTUAL_ELEMENT_WIDTH  value written to every element of run
- drain_start  in  1  request a full drain (sampled in IDLE only)
- drain_busy  out  1  drain in progress
- drain_done  out  1  one-cycle pulse after the last beat is accepted
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  VIRTUAL_ELEMENT_WIDTH  element value
- out_addr  out  VIRTUAL_ADDR_BITS  element address
- out_last  out  1  beat is address varray_len-1
- va_we  out  1  to varray we
- va_write_addr  out  VIRTUAL_ADDR_BITS  to varray write_addr
- va_write_addr_len  out  LEN_BITS  to varray write_addr_len
- va_dat_w  out  VIRTUAL_ELEMENT_WIDTH  to varray dat_w
- va_re  out  1  to varray re
- va_read_addr  out  VIRTUAL_ADDR_BITS  to varray read_addr
- va_dat_r  in  VIRTUAL_ELEMENT_WIDTH  from varray dat_r; valid 1 cycle after va_re
- va_varray_len  in  VIRTUAL_ADDR_BITS  from varray varray_len

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; skid buffer empty; in-flight flag cleared.
  - All outputs 0, including wr_ready.
  - Reset mid-drain aborts immediately; no drain_done pulse.
  - The varray's own reset is driven externally.
- States:
  - IDLE -> DRAIN on drain_start.
  - DRAIN -> IDLE when the last beat handshakes (out_valid & out_ready & out_last).
  - IDLE -> IDLE with a drain_done pulse next cycle if the snapshot length is 0.
- Write path, combinational pass-through:
  - wr_ready = (state==IDLE) & ~drain_start.
  - va_we = wr_valid & wr_ready & (wr_len!=0). va_write_addr, va_write_addr_len and va_dat_w mirror the wr_* inputs.
  - wr_len==0 is accepted but issues no va_we.
  - drain_start and wr_valid in the same cycle: drain wins and the write stalls.
- Drain snapshot:
  - On the drain_start edge, len_q <= va_varray_len and rd_ptr <= 0.
  - Later varray_len changes are ignored; writes are blocked anyway.
- Read issue:
  - va_re = DRAIN & (rd_ptr < len_q) & (skid occupancy + in-flight < 2).
  - va_read_addr = rd_ptr; rd_ptr increments on each va_re.
  - At most one read is in flight. va_dat_r is captured into the skid buffer the cycle after va_re, tagged with its address and last flag (addr == len_q-1).
- Output:
  - Head of skid buffer; out_valid = buffer non-empty.
  - out_data, out_addr and out_last are held stable while out_valid & ~out_ready.
- Latency and throughput:
  - drain_start sampled at edge N: first va_re in cycle N+1, first out_valid in cycle N+2.
  - Sustained 1 beat/cycle with out_ready high.
  - drain_busy and drain_done timing:
    - drain_busy is high from cycle N+1 until the last handshake edge.
    - drain_done pulses exactly 1 cycle, in the cycle after the last handshake.
    - wr_ready rises in that same cycle.
- drain_start while busy is ignored.
- Width rules:
  - rd_ptr and len_q are VIRTUAL_ADDR_BITS wide; no wrap, because len_q ≤ 2^VIRTUAL_ADDR_BITS-1.
  - Comparisons are unsigned.

Decomposition:
- Package varray_pkg: VIRTUAL_ELEMENT_WIDTH, VIRTUAL_ADDR_BITS and LEN_BITS defaults; drain state enum {IDLE, DRAIN}; skid entry struct {data, addr, last}.
- One sub-module: varray_skid, a 2-entry valid/ready FIFO with push/pop and occupancy output.

Test Plan:
- Write (0,len4,12) then (4,len3,6); drain with out_ready=1 -> 7 beats, addr 0..6, data 12,12,12,12,6,6,6, out_last only on addr 6; drain_done 1 cycle after beat 6; 9 cycles from start to done.
- Same contents, out_ready toggling 1,0,1,0... -> identical 7-beat sequence, no drop or duplicate; outputs stable on stalled cycles.
- Same contents, out_ready=0 for 10 cycles after start -> exactly 2 va_re issued (addr 0,1); out_addr=0 and out_data=12 held; release -> remaining beats continue in order.
- va_varray_len=0 at drain_start -> no va_re, no out_valid; drain_done pulse next cycle.
- wr_valid with (20,len2,9) during drain -> wr_ready=0 and va_we=0 until the drain_done cycle; then accepted in 1 cycle; next drain yields len 22 with addr 20,21 = 9.
- Reset low after 3 beats of a 7-beat drain -> all outputs 0 immediately, no drain_done; after release a new drain restarts at addr 0 with all 7 beats.
